// File: rtl/tt_stim_sequencer.sv
// tt_stim_sequencer: reset/enable/stimulus sequencer for a TinyTapeout-style DUT.
// Holds the DUT in reset, releases reset, asserts enable, then steps a pattern
// memory onto dut_ui and captures dut_uo once per step.
// Optional feature macro: STIM_SIGNATURE_EN (response MISR on sig; when the
// macro is undefined, sig stays 0).
//
// Handshake: start and cfg_we are single-cycle strobes with no ready. start is
// accepted only in IDLE or DONE. cfg_we is accepted only while busy=0. abort
// has priority over start in every state.
module tt_stim_sequencer #(
    parameter int W          = 8,
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 3,
    parameter int ENA_CYCLES = 5,
    parameter int HOLD       = 2,
    parameter logic [W-1:0] POLY = 8'h1D
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(DEPTH):0]     num_steps,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [W-1:0]               cfg_data,
    output logic                       dut_rst_n,
    output logic                       dut_ena,
    output logic [W-1:0]               dut_ui,
    input  logic [W-1:0]               dut_uo,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     step,
    output logic [W-1:0]               last_uo,
    output logic [W-1:0]               sig,
    output logic [2:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(ENA_CYCLES + 1);
    localparam int HW = $clog2(HOLD + 1);

`ifdef STIM_SIGNATURE_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state;
    logic [W-1:0]    mem [DEPTH];
    logic [AW:0]     nsteps;
    logic [AW:0]     clamped_steps;
    logic [AW:0]     step_next;
    logic [PW-1:0]   cnt;
    logic [HW-1:0]   hcnt;
    logic [W-1:0]    sig_next;

    assign dbg_state     = state;
    assign clamped_steps = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;
    assign step_next     = step + (AW+1)'(1);
    // MISR step; constant zero (and removed by synthesis) when the signature is disabled
    assign sig_next      = SIG_EN ? (({sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0)) ^ dut_uo) : '0;

    // Pattern memory: writable only while the sequencer is not busy; never reset
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    // Sequencer FSM with all DUT-facing and status outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dut_rst_n <= 1'b0;
            dut_ena   <= 1'b0;
            dut_ui    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step      <= '0;
            last_uo   <= '0;
            sig       <= '0;
            nsteps    <= '0;
            cnt       <= '0;
            hcnt      <= '0;
        end else if (abort) begin
            // last_uo and sig are kept so a host can inspect a partial run
            state     <= S_IDLE;
            dut_rst_n <= 1'b0;
            dut_ena   <= 1'b0;
            dut_ui    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step      <= '0;
            cnt       <= '0;
            hcnt      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RESET;
                        nsteps    <= clamped_steps;
                        step      <= '0;
                        sig       <= '0;
                        dut_rst_n <= 1'b0;
                        dut_ena   <= 1'b0;
                        dut_ui    <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cnt       <= '0;
                        hcnt      <= '0;
                    end
                end
                S_RESET: begin
                    if (cnt == PW'(RST_CYCLES - 1)) begin
                        state     <= S_ARM;
                        dut_rst_n <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                S_ARM: begin
                    if (cnt == PW'(ENA_CYCLES - RST_CYCLES - 1)) begin
                        cnt     <= '0;
                        dut_ena <= 1'b1;
                        if (nsteps != '0) begin
                            state  <= S_RUN;
                            dut_ui <= mem[0];
                            hcnt   <= '0;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                S_RUN: begin
                    if (hcnt == HW'(HOLD - 1)) begin
                        // Last hold cycle: sample the response and advance
                        last_uo <= dut_uo;
                        sig     <= sig_next;
                        step    <= step_next;
                        hcnt    <= '0;
                        if (step_next == nsteps) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            dut_ui <= mem[step_next[AW-1:0]];
                        end
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_stim_sequencer.sv
// Directed bench for tt_stim_sequencer with a ui->uo loopback DUT.
// Cycle k=1 is the first cycle after the edge that accepts start.
module tb_tt_stim_sequencer;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort, cfg_we;
    logic [AW:0]   num_steps;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_data;
    logic          dut_rst_n, dut_ena, busy, done;
    logic [W-1:0]  dut_ui, dut_uo, last_uo, sig;
    logic [AW:0]   step;
    logic [2:0]    dbg_state;

    int vectors = 0;
    int errors  = 0;

    logic [W-1:0]   shadow [DEPTH];
    logic [W+3:0]   trace[$];
    logic [W+3:0]   first_trace[$];

    tt_stim_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_steps(num_steps), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .dut_rst_n(dut_rst_n), .dut_ena(dut_ena),
        .dut_ui(dut_ui), .dut_uo(dut_uo), .busy(busy), .done(done),
        .step(step), .last_uo(last_uo), .sig(sig), .dbg_state(dbg_state)
    );

    // Loopback user design
    assign dut_uo = dut_ui;

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_mem(input int a, input logic [W-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a[AW-1:0];
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
        shadow[a] = d;
    endtask

    task automatic do_start(input int n);
        num_steps = n[AW:0];
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic capture(input int cycles);
        trace.delete();
        for (int c = 0; c < cycles; c++) begin
            trace.push_back({dut_rst_n, dut_ena, busy, done, dut_ui});
            tick();
        end
    endtask

    // Expected {rst_n, ena, busy, done, ui} at cycle k of an n-step run (HOLD=2)
    function automatic logic [W+3:0] model(input int k, input int n);
        logic rn, en, bz, dn;
        logic [W-1:0] ui;
        rn = (k >= 4);
        en = (k >= 6);
        bz = (k >= 1) && (k < 6 + 2*n);
        dn = (k >= 6 + 2*n);
        if (k < 6)               ui = '0;
        else if (k < 6 + 2*n)    ui = shadow[(k-6)/2];
        else if (n > 0)          ui = shadow[n-1];
        else                     ui = '0;
        return {rn, en, bz, dn, ui};
    endfunction

    function automatic logic [W-1:0] misr_model(input int n);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < n; i++) begin
`ifdef STIM_SIGNATURE_EN
            s = ({s[W-2:0], 1'b0} ^ (s[W-1] ? 8'h1D : 8'h00)) ^ shadow[i];
`endif
        end
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        num_steps = '0; cfg_addr = '0; cfg_data = '0;
        tick(); tick();
        vectors++; if (dut_rst_n !== 1'b0) begin errors++; $display("FAIL reset_rst_n got %b exp 0", dut_rst_n); end
        vectors++; if (dut_ena !== 1'b0)   begin errors++; $display("FAIL reset_ena got %b exp 0", dut_ena); end
        vectors++; if (dut_ui !== 8'h00)   begin errors++; $display("FAIL reset_ui got %h exp 00", dut_ui); end
        vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        vectors++; if (step !== 5'd0)      begin errors++; $display("FAIL reset_step got %0d exp 0", step); end
        vectors++; if (last_uo !== 8'h00)  begin errors++; $display("FAIL reset_last_uo got %h exp 00", last_uo); end
        vectors++; if (sig !== 8'h00)      begin errors++; $display("FAIL reset_sig got %h exp 00", sig); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_steps();
        do_start(0);
        capture(8);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (trace[i] !== model(i+1, 0)) begin
                errors++; $display("FAIL zero_trace k=%0d got %h exp %h", i+1, trace[i], model(i+1, 0));
            end
        end
        vectors++; if (sig !== 8'h00) begin errors++; $display("FAIL zero_sig got %h exp 00", sig); end
        vectors++; if (step !== 5'd0) begin errors++; $display("FAIL zero_step got %0d exp 0", step); end
    endtask

    task automatic test_run_basic();
        write_mem(0, 8'h01); write_mem(1, 8'h02); write_mem(2, 8'h04); write_mem(3, 8'h08);
        do_start(4);
        capture(14);
        first_trace = trace;
        for (int i = 0; i < 14; i++) begin
            vectors++;
            if (trace[i] !== model(i+1, 4)) begin
                errors++; $display("FAIL run_trace k=%0d got %h exp %h", i+1, trace[i], model(i+1, 4));
            end
        end
        vectors++; if (last_uo !== 8'h08) begin errors++; $display("FAIL run_last_uo got %h exp 08", last_uo); end
        vectors++; if (step !== 5'd4)     begin errors++; $display("FAIL run_step got %0d exp 4", step); end
        vectors++; if (sig !== misr_model(4)) begin errors++; $display("FAIL run_sig got %h exp %h", sig, misr_model(4)); end
    endtask

    task automatic test_back_to_back();
        do_start(4);
        capture(14);
        for (int i = 0; i < 14; i++) begin
            vectors++;
            if (trace[i] !== first_trace[i] || trace[i] !== model(i+1, 4)) begin
                errors++; $display("FAIL rerun_trace k=%0d got %h exp %h", i+1, trace[i], model(i+1, 4));
            end
        end
        vectors++; if (sig !== misr_model(4)) begin errors++; $display("FAIL rerun_sig got %h exp %h", sig, misr_model(4)); end
    endtask

    task automatic test_abort();
        do_start(4);
        for (int k = 1; k < 8; k++) tick();
        vectors++; if (dut_ui !== shadow[1]) begin errors++; $display("FAIL abort_pre_ui got %h exp %h", dut_ui, shadow[1]); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++; if (dut_rst_n !== 1'b0) begin errors++; $display("FAIL abort_rst_n got %b exp 0", dut_rst_n); end
        vectors++; if (dut_ena !== 1'b0)   begin errors++; $display("FAIL abort_ena got %b exp 0", dut_ena); end
        vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0)      begin errors++; $display("FAIL abort_done got %b exp 0", done); end
        vectors++; if (step !== 5'd0)      begin errors++; $display("FAIL abort_step got %0d exp 0", step); end
        vectors++; if (last_uo !== shadow[0]) begin errors++; $display("FAIL abort_last_uo got %h exp %h", last_uo, shadow[0]); end
        tick();
        do_start(4);
        capture(14);
        for (int i = 0; i < 14; i++) begin
            vectors++;
            if (trace[i] !== model(i+1, 4)) begin
                errors++; $display("FAIL abort_rerun k=%0d got %h exp %h", i+1, trace[i], model(i+1, 4));
            end
        end
        vectors++; if (last_uo !== 8'h08) begin errors++; $display("FAIL abort_rerun_last_uo got %h exp 08", last_uo); end
    endtask

    task automatic test_cfg_busy();
        logic [W+3:0] obs;
        do_start(4);
        for (int k = 1; k <= 14; k++) begin
            obs = {dut_rst_n, dut_ena, busy, done, dut_ui};
            vectors++;
            if (obs !== model(k, 4)) begin
                errors++; $display("FAIL busy_trace k=%0d got %h exp %h", k, obs, model(k, 4));
            end
            if (k == 7) begin cfg_we = 1'b1; cfg_addr = '0; cfg_data = 8'hAA; end
            if (k == 9) start = 1'b1;
            tick();
            cfg_we = 1'b0;
            start  = 1'b0;
        end
        do_start(4);
        capture(8);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (trace[i] !== model(i+1, 4)) begin
                errors++; $display("FAIL busy_rerun k=%0d got %h exp %h", i+1, trace[i], model(i+1, 4));
            end
        end
    endtask

    task automatic test_rst_mid_run();
        do_start(4);
        for (int k = 1; k < 9; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (dut_rst_n !== 1'b0) begin errors++; $display("FAIL midrst_rst_n got %b exp 0", dut_rst_n); end
        vectors++; if (dut_ena !== 1'b0)   begin errors++; $display("FAIL midrst_ena got %b exp 0", dut_ena); end
        vectors++; if (dut_ui !== 8'h00)   begin errors++; $display("FAIL midrst_ui got %h exp 00", dut_ui); end
        vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0)      begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
        vectors++; if (step !== 5'd0)      begin errors++; $display("FAIL midrst_step got %0d exp 0", step); end
        vectors++; if (last_uo !== 8'h00)  begin errors++; $display("FAIL midrst_last_uo got %h exp 00", last_uo); end
        vectors++; if (sig !== 8'h00)      begin errors++; $display("FAIL midrst_sig got %h exp 00", sig); end
        tick();
    endtask

    task automatic test_clamp();
        for (int a = 1; a < DEPTH; a++) write_mem(a, 8'(a * 17) ^ 8'h5A);
        // Write and start in the same IDLE cycle: the run must see the new word
        cfg_we = 1'b1; cfg_addr = '0; cfg_data = 8'hC3;
        num_steps = 5'd20; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        shadow[0] = 8'hC3;
        capture(38);
        for (int i = 0; i < 38; i++) begin
            vectors++;
            if (trace[i] !== model(i+1, 16)) begin
                errors++; $display("FAIL clamp_trace k=%0d got %h exp %h", i+1, trace[i], model(i+1, 16));
            end
        end
        vectors++; if (step !== 5'd16) begin errors++; $display("FAIL clamp_step got %0d exp 16", step); end
        vectors++; if (last_uo !== shadow[15]) begin errors++; $display("FAIL clamp_last_uo got %h exp %h", last_uo, shadow[15]); end
        vectors++; if (sig !== misr_model(16)) begin errors++; $display("FAIL clamp_sig got %h exp %h", sig, misr_model(16)); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_zero_steps();
        test_run_basic();
        test_back_to_back();
        test_abort();
        test_cfg_busy();
        test_rst_mid_run();
        test_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
